// File: rtl/fpu_types_pkg.sv
// Shared FPU datapath types.
// Fractions are 27-bit two's complement with the binary point after bit 25.
package fpu_types_pkg;

    localparam int FRAC_W    = 27;
    localparam int FRAC_SIGN = 26;

    typedef logic [FRAC_W-1:0] frac_t;

endpackage

// File: rtl/adder_26b.sv
// Signed fraction adder with saturating sign on overflow.
// The magnitude bits are kept from the wrapped sum; only the sign is pinned.
module adder_26b
    import fpu_types_pkg::*;
(
    input  frac_t a,
    input  frac_t b,
    output frac_t sum,
    output logic  ovf
);

    frac_t raw;

    assign raw = a + b;

    assign ovf = (a[FRAC_SIGN] == b[FRAC_SIGN]) &&
                 (raw[FRAC_SIGN] != a[FRAC_SIGN]);

    assign sum = {ovf ? a[FRAC_SIGN] : raw[FRAC_SIGN],
                  raw[FRAC_SIGN-1:0]};

endmodule

// File: rtl/frac_adder_arbiter.sv
// Round-robin sharing of one fraction adder between N_REQ requesters,
// each with a one-entry response register.
module frac_adder_arbiter
    import fpu_types_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0][FRAC_W-1:0] req_frac1,
    input  logic [N_REQ-1:0][FRAC_W-1:0] req_frac2,
    output logic [N_REQ-1:0]             rsp_valid,
    input  logic [N_REQ-1:0]             rsp_ready,
    output logic [N_REQ-1:0][FRAC_W-1:0] rsp_sum,
    output logic [N_REQ-1:0]             rsp_ovf
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] sel;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] grant;
    logic             any_grant;
    int               idx;

    frac_t add_a;
    frac_t add_b;
    frac_t add_sum;
    logic  add_ovf;

    // A full response slot still accepts if it is being drained this cycle.
    assign elig = req_valid & (~rsp_valid | rsp_ready);

    always_comb begin
        grant     = '0;
        sel       = last;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!any_grant && elig[idx]) begin
                grant[idx] = 1'b1;
                sel        = IDX_W'(idx);
                any_grant  = 1'b1;
            end
        end
    end

    assign req_ready = nRST ? grant : '0;

    assign add_a = req_frac1[sel];
    assign add_b = req_frac2[sel];

    adder_26b u_adder (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last      <= LAST_RST;
            rsp_valid <= '0;
            rsp_sum   <= '0;
            rsp_ovf   <= '0;
        end else begin
            if (any_grant) begin
                last <= sel;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i]) begin
                    rsp_valid[i] <= 1'b1;
                    rsp_sum[i]   <= add_sum;
                    rsp_ovf[i]   <= add_ovf;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_frac_adder_arbiter.sv
// Self-checking bench for frac_adder_arbiter: vector table, corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_frac_adder_arbiter;

    localparam int N = 2;

    logic                CLK;
    logic                nRST;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0][26:0]  req_frac1;
    logic [N-1:0][26:0]  req_frac2;
    logic [N-1:0]        rsp_valid;
    logic [N-1:0]        rsp_ready;
    logic [N-1:0][26:0]  rsp_sum;
    logic [N-1:0]        rsp_ovf;

    int checks = 0;
    int errors = 0;

    // Reference state: slot contents per port and the last granted port.
    logic        m_vld [N];
    logic [26:0] m_sum [N];
    logic        m_ovf [N];
    int          m_last;

    frac_adder_arbiter #(.N_REQ(N)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_frac1 (req_frac1),
        .req_frac2 (req_frac2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_ovf   (rsp_ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [26:0] a;
        logic [26:0] b;
        logic [26:0] sum;
        logic        ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Signed arithmetic on the true values; overflow means out of range.
    function automatic void ref_add(input logic [26:0] a, input logic [26:0] b,
                                    output logic [26:0] s, output logic o);
        longint sa, sb, tot;
        sa = a[26] ? longint'(a) - 134217728 : longint'(a);
        sb = b[26] ? longint'(b) - 134217728 : longint'(b);
        tot = sa + sb;
        o = (tot > 67108863) || (tot < -67108864);
        s = tot[26:0];
        if (o) s[26] = ~s[26];
    endfunction

    function automatic int ref_grant();
        int g;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (m_last + k) % N;
            if (g < 0 && req_valid[p] && (!m_vld[p] || rsp_ready[p])) g = p;
        end
        return g;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_vld[i] = 1'b0;
            m_sum[i] = '0;
            m_ovf[i] = 1'b0;
        end
        m_last = N - 1;
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic step();
        int g;
        logic [N-1:0] exp_rdy;
        logic [26:0] s;
        logic o;
        #1;
        g = ref_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        @(posedge CLK);
        for (int i = 0; i < N; i++) begin
            if (i == g) begin
                ref_add(req_frac1[i], req_frac2[i], s, o);
                m_vld[i] = 1'b1;
                m_sum[i] = s;
                m_ovf[i] = o;
            end else if (rsp_ready[i]) begin
                m_vld[i] = 1'b0;
            end
        end
        if (g >= 0) m_last = g;
        @(negedge CLK);
        for (int i = 0; i < N; i++) begin
            chk("rsp_valid", rsp_valid[i], m_vld[i]);
            chk("rsp_sum", rsp_sum[i], m_sum[i]);
            chk("rsp_ovf", rsp_ovf[i], m_ovf[i]);
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    function automatic logic [26:0] rnd_frac();
        logic [26:0] v;
        case ($urandom_range(0, 4))
            0: v = 27'h3FFFFFF;
            1: v = 27'h4000000;
            2: v = 27'h7FFFFFF;
            default: v = 27'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        logic [26:0] s0;

        vecs[0] = '{27'h0400000, 27'h0200000, 27'h0600000, 1'b0};
        vecs[1] = '{27'h3000000, 27'h3000000, 27'h2000000, 1'b1};
        vecs[2] = '{27'h4000000, 27'h4000000, 27'h4000000, 1'b1};
        vecs[3] = '{27'h7FFFFFF, 27'h0000001, 27'h0000000, 1'b0};
        vecs[4] = '{27'h1FFFFFF, 27'h0000001, 27'h2000000, 1'b0};
        vecs[5] = '{27'h5000000, 27'h3000000, 27'h0000000, 1'b0};
        vecs[6] = '{27'h3FFFFFF, 27'h0000001, 27'h0000000, 1'b1};

        nRST      = 1'b0;
        req_valid = '1;
        rsp_ready = '0;
        req_frac1 = '0;
        req_frac2 = '0;
        model_reset();
        #12;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_sum", rsp_sum, 0);
        chk("reset_rsp_ovf", rsp_ovf, 0);
        chk("reset_req_ready", req_ready, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // Vector table on port 0.
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        for (int v = 0; v < 7; v++) begin
            req_frac1[0] = vecs[v].a;
            req_frac2[0] = vecs[v].b;
            #1;
            chk("vec_ready", req_ready[0], 1);
            step();
            chk("vec_valid", rsp_valid[0], 1);
            chk("vec_sum", rsp_sum[0], vecs[v].sum);
            chk("vec_ovf", rsp_ovf[0], vecs[v].ovf);
        end

        // Contention: alternate grants starting at port 0.
        req_valid = '0;
        do_reset();
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 6; k++) begin
            req_frac1[0] = 27'(k * 3);
            req_frac2[0] = 27'h0100000;
            req_frac1[1] = 27'(k * 5);
            req_frac2[1] = 27'h7F00000;
            #1;
            chk("cont_grant", req_ready, (k % 2 == 0) ? 1 : 2);
            step();
        end

        // Backpressure on port 0.
        req_valid    = 2'b01;
        rsp_ready    = 2'b00;
        req_frac1[0] = 27'h0123456;
        req_frac2[0] = 27'h0011111;
        step();
        s0 = rsp_sum[0];
        req_valid = 2'b11;
        rsp_ready = 2'b10;
        for (int k = 0; k < 4; k++) begin
            req_frac1[0] = 27'($urandom);
            req_frac2[0] = 27'($urandom);
            req_frac1[1] = 27'($urandom);
            req_frac2[1] = 27'($urandom);
            #1;
            chk("bp_grant", req_ready, 2);
            step();
            chk("bp_hold", rsp_sum[0], s0);
        end
        rsp_ready    = 2'b11;
        req_frac1[0] = 27'h0000100;
        req_frac2[0] = 27'h0000200;
        #1;
        chk("bp_release_grant", req_ready, 1);
        step();
        chk("bp_release_valid", rsp_valid[0], 1);
        chk("bp_release_sum", rsp_sum[0], 27'h0000300);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_frac1[i] = rnd_frac();
                req_frac2[i] = rnd_frac();
            end
            step();
        end

        // Reset the cycle after an accept.
        req_valid    = 2'b01;
        rsp_ready    = 2'b00;
        req_frac1[0] = 27'h0000007;
        req_frac2[0] = 27'h0000001;
        step();
        req_valid = 2'b11;
        nRST = 1'b0;
        model_reset();
        #1;
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_ready", req_ready, 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("midrst_hold_valid", rsp_valid, 0);
        nRST = 1'b1;
        #1;
        chk("midrst_first_grant", req_ready, 1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
